// File: rtl/mem_write_checker.sv
// Self-check monitor for the ARM `top` store port: watches every store, reaches a
// single registered pass/fail/timeout verdict and keeps cycle and store counters.
module mem_write_checker #(
  parameter logic [31:0] PASS_ADR  = 32'd100,
  parameter logic [31:0] PASS_DATA = 32'd7,
  parameter logic [31:0] ALLOW_ADR = 32'd96,
  parameter int          TIMEOUT   = 1000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [31:0]      DataAdr,
  input  logic [31:0]      WriteData,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] write_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [31:0]      fail_adr,
  output logic [31:0]      fail_data
);

  typedef enum logic [1:0] {RUN, PASS, FAIL, TMO} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] write_count_q, write_count_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [31:0]      fail_adr_q, fail_adr_d;
  logic [31:0]      fail_data_q, fail_data_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    state_d       = state_q;
    write_count_d = write_count_q;
    cycle_count_d = cycle_count_q;
    fail_adr_d    = fail_adr_q;
    fail_data_d   = fail_data_q;

    if (state_q == RUN) begin
      if (cycle_count_q != CNT_MAX) cycle_count_d = cycle_count_q + 1'b1;

      // A store verdict on the last RUN cycle takes precedence over timeout.
      if (MemWrite && DataAdr == PASS_ADR && WriteData == PASS_DATA) begin
        state_d = PASS;
      end else if (MemWrite && DataAdr != ALLOW_ADR) begin
        state_d     = FAIL;
        fail_adr_d  = DataAdr;
        fail_data_d = WriteData;
      end else begin
        if (MemWrite && write_count_q != CNT_MAX) write_count_d = write_count_q + 1'b1;
        if (cycle_count_q == TMO_LAST) state_d = TMO;
      end
    end

    done_d    = (state_d != RUN);
    pass_d    = (state_d == PASS);
    fail_d    = (state_d == FAIL);
    timeout_d = (state_d == TMO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      write_count_q <= '0;
      cycle_count_q <= '0;
      fail_adr_q    <= '0;
      fail_data_q   <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_count_q <= write_count_d;
      cycle_count_q <= cycle_count_d;
      fail_adr_q    <= fail_adr_d;
      fail_data_q   <= fail_data_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      timeout_q     <= timeout_d;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign write_count = write_count_q;
  assign cycle_count = cycle_count_q;
  assign fail_adr    = fail_adr_q;
  assign fail_data   = fail_data_q;

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable self-check block downstream of the multicycle ARM `top` data-memory write port.
- Observes every store `top` issues and decides end-of-program pass/fail in hardware.
- Captures the offending write and counts cycles and stores, so FPGA runs and simulations share one verdict source.
- Sits beside `top` in the test harness and consumes `MemWrite`, `DataAdr` and `WriteData` unmodified.

Parameters:
- PASS_ADR, 32'd100: store address that ends the program.
- PASS_DATA, 32'd7: data required at PASS_ADR for a pass.
- ALLOW_ADR, 32'd96: scratch address whose stores are permitted with any data.
- TIMEOUT, 1000: cycles in RUN without a verdict before declaring timeout; legal range 2..2^CNT_W-1.
- CNT_W, 16: width of the cycle and store counters.

Ports:
- clk, in, 1: system clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- MemWrite, in, 1: store strobe from `top`.
- DataAdr, in, 32: store address from `top`.
- WriteData, in, 32: store data from `top`.
- done, out, 1: a verdict has been reached.
- pass, out, 1: program wrote PASS_DATA to PASS_ADR.
- fail, out, 1: illegal store observed.
- timeout, out, 1: TIMEOUT reached with no verdict.
- write_count, out, CNT_W: accepted ALLOW_ADR stores.
- cycle_count, out, CNT_W: cycles spent in RUN.
- fail_adr, out, 32: address of the first illegal store.
- fail_data, out, 32: data of the first illegal store.

Behaviour:
- States: RUN, PASS, FAIL, TMO. All outputs are registered.
- Reset (rising edge with reset=1): state=RUN; every output is 0, including counters and fail capture.
  - reset takes priority over all other inputs.
  - reset asserted mid-run or in a terminal state returns the block to RUN with all outputs 0 on the next edge.
- RUN, evaluated on each edge with MemWrite=1, in priority order:
  1. DataAdr==PASS_ADR and WriteData==PASS_DATA: go to PASS.
  2. Otherwise, DataAdr!=ALLOW_ADR: go to FAIL and latch fail_adr=DataAdr, fail_data=WriteData. This includes PASS_ADR with wrong data.
  3. Otherwise (DataAdr==ALLOW_ADR): stay in RUN; write_count += 1, saturating at all-ones.
- RUN with MemWrite=0: no action on address or data, whatever their values.
- cycle_count:
  - Increments by 1 on every edge spent in RUN, including the edge that leaves RUN.
  - Frozen in terminal states.
  - Saturates at all-ones.
- Timeout: in RUN, when cycle_count==TIMEOUT-1 and no verdict is taken on that edge, go to TMO. Total RUN cycles at timeout = TIMEOUT.
- Simultaneous events: a store verdict on the TIMEOUT-1 edge wins over timeout.
- Terminal states PASS, FAIL and TMO are sticky until reset. Later stores are ignored, and counters and fail capture do not change.
- Flags:
  - done=1 in any terminal state.
  - Exactly one of pass/fail/timeout is 1 when done=1; all are 0 in RUN.
- Latency: the verdict is visible one clock after the rising edge on which the store is sampled.
- Width rules:
  - Address and data compares are full 32-bit equality.
  - Counters are unsigned and never wrap.

Test Plan:
- Reset, then ALLOW_ADR stores (96,3), (96,4), then (100,7): pass=1, done=1 one cycle later; write_count=2; fail=timeout=0.
- Reset, then store (100,8): fail=1; fail_adr=100; fail_data=8; write_count=0.
- Reset, then store (64,7), then (100,7): fail=1 with fail_adr=64, fail_data=7; the later store does not change state, flags or capture.
- TIMEOUT=20, MemWrite held 0: timeout=1 after exactly 20 RUN cycles with cycle_count=20. Repeat with (100,7) on the 20th cycle: pass=1 and timeout=0.
- Assert reset for one cycle while in FAIL: next cycle all outputs are 0 and state is RUN. Then (100,7): pass=1.
- MemWrite=0 with DataAdr=100, WriteData=7 held for 10 cycles: no verdict; cycle_count=10; write_count=0.
